// File: rtl/intersection_phase_sched_pkg.sv
// Shared types for the intersection scheduler: phase encoding, lamp
// structs, the phase-to-lamp decode and duration clamping.
package tlc_pkg;

  typedef enum logic [2:0] {
    ALLRED_A = 3'd0,
    A_GREEN  = 3'd1,
    A_YELLOW = 3'd2,
    ALLRED_B = 3'd3,
    B_GREEN  = 3'd4,
    B_YELLOW = 3'd5
  } phase_e;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  typedef struct packed {
    lamp_t a;
    lamp_t b;
  } heads_t;

  localparam lamp_t LAMP_RED    = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
  localparam lamp_t LAMP_YELLOW = '{red: 1'b0, yellow: 1'b1, green: 1'b0};
  localparam lamp_t LAMP_GREEN  = '{red: 1'b0, yellow: 1'b0, green: 1'b1};

  // Both heads default to red; only the four moving phases light anything else.
  function automatic heads_t phase_lamps(phase_e p);
    heads_t h;
    h.a = LAMP_RED;
    h.b = LAMP_RED;
    case (p)
      A_GREEN:  h.a = LAMP_GREEN;
      A_YELLOW: h.a = LAMP_YELLOW;
      B_GREEN:  h.b = LAMP_GREEN;
      B_YELLOW: h.b = LAMP_YELLOW;
      default:  ;
    endcase
    return h;
  endfunction

  // A zero duration would stall the counter at 0, so it is run as one tick.
  function automatic logic [7:0] clamp_dur(logic [7:0] d);
    return (d == 8'd0) ? 8'd1 : d;
  endfunction

endpackage

// File: rtl/intersection_phase_sched_if.sv
// Control/status bundle between the scheduler (slave) and its user (master).
interface intersection_phase_sched_if;
  logic       tick;
  logic       veh_b;
  logic [1:0] ped_req;
  logic [1:0] ped_ack;
  logic       a_red, a_yellow, a_green;
  logic       b_red, b_yellow, b_green;
  logic [2:0] phase;
  logic [7:0] countdown;

  modport slave (
    input  tick, veh_b, ped_req,
    output ped_ack, a_red, a_yellow, a_green, b_red, b_yellow, b_green,
           phase, countdown
  );

  modport master (
    output tick, veh_b, ped_req,
    input  ped_ack, a_red, a_yellow, a_green, b_red, b_yellow, b_green,
           phase, countdown
  );
endinterface

// File: rtl/intersection_phase_sched_timer.sv
// Loadable 8-bit phase down-counter. A load wins over the tick decrement;
// the count holds at 1 until the owner reloads it on expiry.
module tlc_phase_timer #(
  parameter logic [7:0] RST_VAL = 8'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] count_o,
  output logic       expire_o
);

  logic [7:0] count_q, count_d;

  // Next count: priority load, else tick-enabled decrement floored at 1.
  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = load_val_i;
    else if (tick_i && (count_q > 8'd1))
      count_d = count_q - 8'd1;
  end

  // Count register; reset is asynchronous and asserted high.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) count_q <= RST_VAL;
    else       count_q <= count_d;
  end

  assign count_o  = count_q;
  assign expire_o = tick_i && (count_q == 8'd1);

endmodule

// File: rtl/intersection_phase_sched.sv
// Two-approach intersection phase scheduler.
// Optional feature macro: TLC_PED_REQ_EN enables pedestrian latches,
// green shortening and ped_ack; without it ped_req is ignored.
module intersection_phase_sched
  import tlc_pkg::*;
#(
  parameter int T_GREEN_A = 60,
  parameter int T_GREEN_B = 30,
  parameter int T_YELLOW  = 5,
  parameter int T_ALLRED  = 2,
  parameter int T_PED     = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  intersection_phase_sched_if.slave  bus
);

  localparam logic [7:0] D_GA  = clamp_dur(8'(T_GREEN_A));
  localparam logic [7:0] D_GB  = clamp_dur(8'(T_GREEN_B));
  localparam logic [7:0] D_Y   = clamp_dur(8'(T_YELLOW));
  localparam logic [7:0] D_AR  = clamp_dur(8'(T_ALLRED));
  localparam logic [7:0] D_PED = clamp_dur(8'(T_PED));

  phase_e     phase_q, phase_d;
  logic [1:0] pl_q, pl_d;
  logic [1:0] ack_q, ack_d;
  heads_t     lamps_q;
  logic [1:0] pl_eff;
  logic [7:0] count;
  logic       expire, load, shorten, b_demand;
  logic [7:0] load_val;

  function automatic logic [7:0] dur_of(phase_e p);
    case (p)
      A_GREEN:            return D_GA;
      B_GREEN:            return D_GB;
      A_YELLOW, B_YELLOW: return D_Y;
      default:            return D_AR;
    endcase
  endfunction

  function automatic phase_e next_phase(phase_e p);
    case (p)
      ALLRED_A: return A_GREEN;
      A_GREEN:  return A_YELLOW;
      A_YELLOW: return ALLRED_B;
      ALLRED_B: return B_GREEN;
      B_GREEN:  return B_YELLOW;
      default:  return ALLRED_A;
    endcase
  endfunction

  tlc_phase_timer #(.RST_VAL(D_AR)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (bus.tick),
    .load_i     (load),
    .load_val_i (load_val),
    .count_o    (count),
    .expire_o   (expire)
  );

  // Pending pedestrian demand including a request sampled this edge;
  // requests for a crossing that is already safe never latch.
  always_comb begin
    pl_eff = 2'b00;
`ifdef TLC_PED_REQ_EN
    pl_eff[0] = pl_q[0] | (bus.ped_req[0] & (phase_q != B_GREEN));
    pl_eff[1] = pl_q[1] | (bus.ped_req[1] & (phase_q != A_GREEN));
`endif
  end

  // Phase sequencing, timer reload/shortening and acknowledge generation.
  always_comb begin
    phase_d  = phase_q;
    load     = 1'b0;
    load_val = count;
    b_demand = bus.veh_b | pl_eff[0];
    shorten  = (((phase_q == A_GREEN) && pl_eff[0]) ||
                ((phase_q == B_GREEN) && pl_eff[1])) && (count > D_PED);
    if (expire) begin
      load = 1'b1;
      if ((phase_q == A_GREEN) && !b_demand) begin
        load_val = D_GA;
      end else begin
        phase_d  = next_phase(phase_q);
        load_val = dur_of(next_phase(phase_q));
      end
    end else if (shorten) begin
      load     = 1'b1;
      load_val = D_PED;
    end
    ack_d = 2'b00;
    pl_d  = pl_eff;
    if ((phase_d == B_GREEN) && (phase_q != B_GREEN)) begin
      ack_d[0] = pl_eff[0];
      pl_d[0]  = 1'b0;
    end
    if ((phase_d == A_GREEN) && (phase_q != A_GREEN)) begin
      ack_d[1] = pl_eff[1];
      pl_d[1]  = 1'b0;
    end
  end

  // State, latch, ack and lamp registers; lamps decode the next phase so
  // they change on the same edge as phase.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      phase_q <= ALLRED_A;
      pl_q    <= 2'b00;
      ack_q   <= 2'b00;
      lamps_q <= phase_lamps(ALLRED_A);
    end else begin
      phase_q <= phase_d;
      pl_q    <= pl_d;
      ack_q   <= ack_d;
      lamps_q <= phase_lamps(phase_d);
    end
  end

  assign bus.phase     = phase_q;
  assign bus.countdown = count;
  assign bus.ped_ack   = ack_q;
  assign bus.a_red     = lamps_q.a.red;
  assign bus.a_yellow  = lamps_q.a.yellow;
  assign bus.a_green   = lamps_q.a.green;
  assign bus.b_red     = lamps_q.b.red;
  assign bus.b_yellow  = lamps_q.b.yellow;
  assign bus.b_green   = lamps_q.b.green;

endmodule

// File: tb/tb_intersection_phase_sched.sv
// Scoreboard bench for intersection_phase_sched: a driver steps a
// rule-level reference model each clock and queues the expected outputs;
// a monitor pops and compares after every edge.
module tb_intersection_phase_sched;

  localparam int TGA = 4, TGB = 3, TY = 2, TAR = 1, TPED = 2;
`ifdef TLC_PED_REQ_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  typedef struct {
    int       phase;
    int       cnt;
    bit [1:0] ack;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  bit   in_reset;
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;
  exp_t sbq[$];

  int       m_phase, m_cnt;
  bit [1:0] m_pl;
  int       dur[6];

  intersection_phase_sched_if bus ();

  intersection_phase_sched #(
    .T_GREEN_A(TGA), .T_GREEN_B(TGB), .T_YELLOW(TY),
    .T_ALLRED(TAR), .T_PED(TPED)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int cl(int d);
    return (d == 0) ? 1 : d;
  endfunction

  // Lamp {red,yellow,green} for head 0 (A) or 1 (B) in phase p.
  function automatic bit [2:0] lamp_of(int head, int p);
    if (head == 0) return (p == 1) ? 3'b001 : (p == 2) ? 3'b010 : 3'b100;
    return (p == 4) ? 3'b001 : (p == 5) ? 3'b010 : 3'b100;
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_cnt   = cl(TAR);
    m_pl    = 2'b00;
    sbq.delete();
  endtask

  task automatic model_step(bit t, bit v, bit [1:0] r, output exp_t e);
    bit [1:0] ple;
    int prev;
    ple[0] = PED_EN && (m_pl[0] || (r[0] && m_phase != 4));
    ple[1] = PED_EN && (m_pl[1] || (r[1] && m_phase != 1));
    prev   = m_phase;
    e.ack  = 2'b00;
    if (t && m_cnt == 1) begin
      if (m_phase == 1 && !(v || ple[0])) m_cnt = dur[1];
      else begin
        m_phase = (m_phase + 1) % 6;
        m_cnt   = dur[m_phase];
      end
    end else if (((m_phase == 1 && ple[0]) || (m_phase == 4 && ple[1])) && m_cnt > cl(TPED))
      m_cnt = cl(TPED);
    else if (t && m_cnt > 1)
      m_cnt = m_cnt - 1;
    if (m_phase == 4 && prev != 4) begin e.ack[0] = ple[0]; ple[0] = 1'b0; end
    if (m_phase == 1 && prev != 1) begin e.ack[1] = ple[1]; ple[1] = 1'b0; end
    m_pl    = ple;
    e.phase = m_phase;
    e.cnt   = m_cnt;
  endtask

  task automatic do_cycle(bit t, bit v, bit [1:0] r);
    exp_t e;
    @(negedge clk);
    bus.tick    = t;
    bus.veh_b   = v;
    bus.ped_req = r;
    @(posedge clk);
    if (!in_reset) begin
      model_step(t, v, r, e);
      sbq.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_phase"}, bus.phase, 0);
    check({tag, "_countdown"}, bus.countdown, cl(TAR));
    check({tag, "_lamps_a"}, {bus.a_red, bus.a_yellow, bus.a_green}, 3'b100);
    check({tag, "_lamps_b"}, {bus.b_red, bus.b_yellow, bus.b_green}, 3'b100);
    check({tag, "_ped_ack"}, bus.ped_ack, 0);
  endtask

  // Monitor: outputs are valid every cycle, so each queued entry is
  // compared one time unit after the edge that produced it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        txn++;
        $display("txn %0d phase %0d countdown %0d ped_ack %b", txn, bus.phase, bus.countdown, bus.ped_ack);
        check("phase", bus.phase, e.phase);
        check("countdown", bus.countdown, e.cnt);
        check("ped_ack", bus.ped_ack, e.ack);
        check("lamps_a", {bus.a_red, bus.a_yellow, bus.a_green}, lamp_of(0, e.phase));
        check("lamps_b", {bus.b_red, bus.b_yellow, bus.b_green}, lamp_of(1, e.phase));
      end
    end
  end

  initial begin
    int k;
    dur[0] = cl(TAR); dur[1] = cl(TGA); dur[2] = cl(TY);
    dur[3] = cl(TAR); dur[4] = cl(TGB); dur[5] = cl(TY);
    bus.tick = 1'b1; bus.veh_b = 1'b0; bus.ped_req = 2'b00;
    rst_n = 1'b1; in_reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");

    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    in_reset = 1'b0;

    // No demand: A rests in green.
    repeat (20) do_cycle(1'b1, 1'b0, 2'b00);
    // Single vehicle pulse then a full B cycle.
    do_cycle(1'b1, 1'b1, 2'b00);
    repeat (14) do_cycle(1'b1, 1'b0, 2'b00);

    // Pedestrian crossing A while A green shows a full countdown.
    for (k = 0; k < 50 && !(m_phase == 1 && m_cnt == cl(TGA)); k++)
      do_cycle(1'b1, 1'b0, 2'b00);
    check("reach_a_green_full", (m_phase == 1 && m_cnt == cl(TGA)) ? 1 : 0, 1);
    do_cycle(1'b1, 1'b0, 2'b01);
    repeat (12) do_cycle(1'b1, 1'b0, 2'b00);

    // Pedestrian crossing A while already safe in B green.
    for (k = 0; k < 50 && m_phase != 4; k++) do_cycle(1'b1, 1'b1, 2'b00);
    check("reach_b_green", m_phase, 4);
    repeat (2) do_cycle(1'b1, 1'b0, 2'b01);
    repeat (12) do_cycle(1'b1, 1'b0, 2'b00);

    // Randomized traffic, first with a free-running tick, then sparse ticks.
    repeat (300)
      do_cycle(1'b1, ($urandom_range(0, 7) == 0), {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)});
    repeat (300)
      do_cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
               {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)});

    // Reset asserted in the middle of B yellow.
    for (k = 0; k < 60 && m_phase != 5; k++) do_cycle(1'b1, 1'b1, 2'b00);
    check("reach_b_yellow", m_phase, 5);
    #2 rst_n = 1'b1;
    in_reset = 1'b1;
    #1 check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    in_reset = 1'b0;
    repeat (40)
      do_cycle(1'b1, ($urandom_range(0, 5) == 0), {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)});

    @(posedge clk);
    #2 check("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intersection_phase_sched.md
# intersection_phase_sched

Two-approach intersection scheduler that sequences the main-road (A) and side-road (B) signal heads through green, yellow and all-red phases. It arbitrates the shared crossing between vehicle demand on B and pedestrian requests on both approaches. It sits above the per-head lamp drivers, runs from a slow `tick` strobe, and exports phase, lamps and a countdown for display.

## Interface
- `T_GREEN_A`, 60: minimum A green, in ticks
- `T_GREEN_B`, 30: B green, in ticks
- `T_YELLOW`, 5: yellow duration, in ticks, for both approaches
- `T_ALLRED`, 2: all-red clearance, in ticks
- `T_PED`, 10: green remaining after a pedestrian shorten, in ticks
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-high
- `tick`  in  1  one-cycle timing strobe; all durations count ticks
- `veh_b`  in  1  side-road vehicle detector, level
- `ped_req`  in  2  pedestrian request, level or pulse; bit0 crosses road A, bit1 crosses road B
- `ped_ack`  out  2  one-cycle pulse when the requested crossing becomes safe
- `a_red`, `a_yellow`, `a_green`  out  1 each  head A lamps, registered
- `b_red`, `b_yellow`, `b_green`  out  1 each  head B lamps, registered
- `phase`  out  3  current phase code
- `countdown`  out  8  ticks remaining in the current phase

## Operation
- Phases (FSM): `ALLRED_A` → `A_GREEN` → `A_YELLOW` → `ALLRED_B` → `B_GREEN` → `B_YELLOW` → `ALLRED_A`.
- Lamps are decoded from the phase:
  - `A_GREEN`: A green, B red.
  - `A_YELLOW`: A yellow, B red.
  - `B_GREEN`: B green, A red.
  - `B_YELLOW`: B yellow, A red.
  - Both all-red phases: A red, B red.
- Exactly one lamp per head is lit at all times.
- Reset values:
  - Phase is `ALLRED_A`; `countdown` = `T_ALLRED`.
  - `a_red` = `b_red` = 1; all other lamps 0.
  - `ped_ack` = 0; pedestrian latches cleared.
- Per-phase timer rules, on `tick`:
  - If `countdown` > 1, it decrements.
  - If `countdown` == 1, the phase advances and `countdown` loads the next phase's duration.
  - A duration parameter of 0 is treated as 1.
- `A_GREEN` expiry:
  - Advances to `A_YELLOW` only if B demand is pending. B demand = `veh_b` sampled high, or the ped0 latch set.
  - Otherwise `countdown` reloads `T_GREEN_A` and the phase stays in `A_GREEN`. A rests in green indefinitely.
- `B_GREEN` always expires to `B_YELLOW`; B never rests in green.
- Pedestrian latch `pl[i]` is set when `ped_req[i]` is sampled high.
  - Exception: a request for a crossing that is already safe is ignored (no latch, no ack). Crossing 0 is safe in `B_GREEN`; crossing 1 is safe in `A_GREEN`.
- Green shortening:
  - Applies while in `A_GREEN` with `pl[0]` set, or in `B_GREEN` with `pl[1]` set.
  - If `countdown` > `T_PED`, `countdown` is forced to `T_PED` on the next edge, with or without a tick.
- `ped_ack[0]` pulses and `pl[0]` clears on the edge that enters `B_GREEN`. `ped_ack[1]` and `pl[1]` behave the same on entry to `A_GREEN`.
- Simultaneous events:
  - Expiry (`countdown` == 1 with `tick`) beats shortening.
  - Shortening beats a plain decrement: `countdown` becomes `T_PED`, not `T_PED`-1.
  - A request arriving on the same edge as its ack is consumed by that ack.

## Timing
- All outputs are registered and change on the same `clk` edge as `phase`. Lamp latency from the expiring tick is 1 cycle.
- Shortening takes effect 1 cycle after `ped_req` is sampled.
- `countdown` never reads 0 outside reset.
- Assertion of `rst_n` mid-phase returns immediately to the reset values, including in the middle of yellow.
- `tick` may be tied high; all counts then run in clock cycles.

## Configuration
- Macro: `TLC_PED_REQ_EN`.
- Defined: pedestrian latches, shortening and `ped_ack` behave as specified above.
- Undefined:
  - `ped_req` is ignored and `ped_ack` is tied to 0.
  - B demand comes from `veh_b` only.
  - Phase timing uses the full durations.

## Structure
- Shared package `tlc_pkg`:
  - Phase enum with the 3-bit encoding: `ALLRED_A`=0, `A_GREEN`=1, `A_YELLOW`=2, `ALLRED_B`=3, `B_GREEN`=4, `B_YELLOW`=5.
  - Lamp struct `{red, yellow, green}`.
  - Function mapping phase to the two lamp structs.
- Sub-module `tlc_phase_timer`: 8-bit loadable down-counter with `tick` enable, a priority load input, and an `expire` output (`countdown` == 1 and `tick`).

## Test plan
Parameters for all scenarios: `T_GREEN_A`=4, `T_GREEN_B`=3, `T_YELLOW`=2, `T_ALLRED`=1, `T_PED`=2; `tick`=1 every cycle.
- Reset release:
  - Cycle 0: `ALLRED_A`, `countdown`=1, both reds lit.
  - Cycle 1: `A_GREEN`, `countdown`=4.
- No demand:
  - `A_GREEN` reloads to 4 after every expiry; `b_red` stays 1 for 20 cycles.
- `veh_b` pulsed during `A_GREEN`:
  - `A_YELLOW` for 2 cycles, then `ALLRED_B` for 1, `B_GREEN` for 3, `B_YELLOW` for 2, `ALLRED_A` for 1, then back to `A_GREEN`.
- `ped_req[0]` at `countdown`=4 in `A_GREEN`:
  - Next edge: `countdown`=2.
  - Yellow follows 2 cycles later.
  - `ped_ack[0]` pulses on the edge entering `B_GREEN`.
- `ped_req[0]` asserted during `B_GREEN`: no latch, no ack, no shortening.
- `rst_n` asserted during `B_YELLOW`: immediately `ALLRED_A`, both reds lit, `countdown`=1.
  - With `TLC_PED_REQ_EN` undefined, repeat the `ped_req[0]` scenario: `countdown` is unaffected and `ped_ack` stays 0.
